// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-requester arbiter and sequencer for the LC3 data-memory bus
// Optional access timeout enabled by defining DATA_MEM_ARB_TIMEOUT_EN.
module data_mem_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        r0_req,
    input  logic        r1_req,
    input  logic        r0_rd,
    input  logic        r1_rd,
    input  logic [15:0] r0_addr,
    input  logic [15:0] r1_addr,
    input  logic [15:0] r0_wdata,
    input  logic [15:0] r1_wdata,
    output logic        r0_gnt,
    output logic        r1_gnt,
    output logic        r0_done,
    output logic        r1_done,
    output logic [15:0] rdata,
    output logic        err,
    output logic        mem_en,
    output logic [15:0] Data_addr,
    output logic [15:0] Data_din,
    output logic        Data_rd,
    input  logic [15:0] Data_dout,
    input  logic        complete_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   last_owner;
    logic   pick;

    // Only a tie consults last_owner; a lone request always wins.
    assign pick = (r0_req && r1_req) ? ~last_owner : r1_req;

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_below_minimum
    end

`ifdef DATA_MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            r0_gnt     <= 1'b0;
            r1_gnt     <= 1'b0;
            r0_done    <= 1'b0;
            r1_done    <= 1'b0;
            mem_en     <= 1'b0;
            rdata      <= 16'h0000;
            Data_addr  <= 16'h0000;
            Data_din   <= 16'h0000;
            Data_rd    <= 1'b1;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
            err        <= 1'b0;
            cnt        <= '0;
`endif
        end else begin
            r0_gnt  <= 1'b0;
            r1_gnt  <= 1'b0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        owner      <= pick;
                        last_owner <= pick;
                        Data_rd    <= pick ? r1_rd : r0_rd;
                        Data_addr  <= pick ? r1_addr : r0_addr;
                        Data_din   <= pick ? r1_wdata : r0_wdata;
                        r0_gnt     <= ~pick;
                        r1_gnt     <= pick;
                        mem_en     <= 1'b1;
                        state      <= BUSY;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
                        cnt        <= '0;
`endif
                    end
                end
                BUSY: begin
                    // A response arriving on the limit cycle still counts as success.
                    if (complete_data) begin
                        if (Data_rd) begin
                            rdata <= Data_dout;
                        end
                        mem_en  <= 1'b0;
                        r0_done <= ~owner;
                        r1_done <= owner;
                        state   <= DONE;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
                        err     <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        rdata   <= 16'hDEAD;
                        err     <= 1'b1;
                        mem_en  <= 1'b0;
                        r0_done <= ~owner;
                        r1_done <= owner;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
`ifdef DATA_MEM_ARB_TIMEOUT_EN
                    err   <= 1'b0;
`endif
                end
                default: begin
                    state  <= IDLE;
                    mem_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
